frame_buf_arbiter: RTL

Schedules SDRAM burst accesses between the camera write channel (OV5640 capture FIFO) and the display read channel (the FIFO feeding the TFT timing controller's data_req/data_in path). Keeps two frame banks in ping-pong: the camera writes one bank while the display reads the last completed bank. Runs entirely in the SDRAM controller clock domain. FIFO levels and vsync pulses arrive already synchronized.

---
 rtl/frame_buf_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/frame_buf_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : frame_buf_arbiter
// Purpose  : Ping-pong SDRAM burst scheduler between the camera write FIFO
//            and the display read FIFO. The camera fills one bank while the
//            display reads the last completed bank.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buf_arbiter #(
  parameter int ADDR_W        = 24,
  parameter int LEVEL_W       = 10,
  parameter int BURST_LEN     = 256,
  parameter int RD_FIFO_DEPTH = 1024,
  parameter int FRAME_WORDS   = 384000,
  parameter int BANK_BIT      = 19
) (
  input  logic               clk100m,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] wr_level,
  input  logic [LEVEL_W-1:0] rd_level,
  input  logic               wr_vsync,
  input  logic               rd_vsync,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_wr,
  output logic [ADDR_W-1:0]  cmd_addr,
  input  logic               burst_done,
  output logic               busy,
  output logic               frame_ready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_BUSY = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_BUSY = 3'd4
  } state_t;

  localparam logic [BANK_BIT-1:0]         c_frame     = BANK_BIT'(FRAME_WORDS);
  localparam logic [BANK_BIT-1:0]         c_burst     = BANK_BIT'(BURST_LEN);
  localparam logic [31:0]                 c_wr_thresh = 32'(BURST_LEN);
  localparam logic [31:0]                 c_rd_thresh = 32'(RD_FIFO_DEPTH - BURST_LEN);
  localparam logic [ADDR_W-BANK_BIT-2:0]  c_pad       = '0;

  state_t                r_state, w_state_nxt;
  logic [BANK_BIT-1:0]   r_wr_off, w_wr_off_nxt;
  logic [BANK_BIT-1:0]   r_rd_off, w_rd_off_nxt;
  logic                  r_wr_bank, w_wr_bank_nxt;
  logic                  r_rd_bank, w_rd_bank_nxt;
  logic                  r_last_full, w_last_full_nxt;
  logic                  r_wr_pend, w_wr_pend_nxt;
  logic                  r_rd_pend, w_rd_pend_nxt;
  logic                  r_last_wr, w_last_wr_nxt;   // 1 = last grant was write
  logic                  r_frame_ready, w_frame_ready_nxt;
  logic                  r_cmd_valid, w_cmd_valid_nxt;
  logic                  r_cmd_wr, w_cmd_wr_nxt;
  logic [ADDR_W-1:0]     r_cmd_addr, w_cmd_addr_nxt;
  logic                  w_apply;
  logic                  w_lfb;
  logic                  w_wr_elig;
  logic                  w_rd_elig;

  // Levels are widened to 32 bits so the threshold compares cannot wrap.
  assign w_wr_elig = (32'(wr_level) >= c_wr_thresh) && (r_wr_off < c_frame);
  assign w_rd_elig = (32'(rd_level) <= c_rd_thresh);
  assign w_apply   = (r_state == S_IDLE) && (r_wr_pend || r_rd_pend);

  // Next-state, bank/offset bookkeeping and command outputs.
  always_comb begin
    w_state_nxt       = r_state;
    w_wr_off_nxt      = r_wr_off;
    w_rd_off_nxt      = r_rd_off;
    w_wr_bank_nxt     = r_wr_bank;
    w_rd_bank_nxt     = r_rd_bank;
    w_last_full_nxt   = r_last_full;
    w_last_wr_nxt     = r_last_wr;
    w_frame_ready_nxt = r_frame_ready;
    w_cmd_valid_nxt   = r_cmd_valid;
    w_cmd_wr_nxt      = r_cmd_wr;
    w_cmd_addr_nxt    = r_cmd_addr;
    w_lfb             = r_last_full;
    // A fresh vsync arriving while the old flag is being applied is kept.
    w_wr_pend_nxt     = (w_apply ? 1'b0 : r_wr_pend) | wr_vsync;
    w_rd_pend_nxt     = (w_apply ? 1'b0 : r_rd_pend) | rd_vsync;

    case (r_state)
      S_IDLE: begin
        if (w_apply) begin
          // Write side first so a simultaneous read vsync sees the new bank.
          if (r_wr_pend) begin
            if (r_wr_off == c_frame) begin
              w_lfb             = r_wr_bank;
              w_wr_bank_nxt     = ~r_wr_bank;
              w_frame_ready_nxt = 1'b1;
            end
            w_wr_off_nxt = '0;
          end
          w_last_full_nxt = w_lfb;
          if (r_rd_pend) begin
            w_rd_off_nxt  = '0;
            w_rd_bank_nxt = w_lfb;
          end
        end else if (w_wr_elig && (!w_rd_elig || !r_last_wr)) begin
          w_state_nxt     = S_WR_REQ;
          w_cmd_valid_nxt = 1'b1;
          w_cmd_wr_nxt    = 1'b1;
          w_cmd_addr_nxt  = {c_pad, r_wr_bank, r_wr_off};
        end else if (w_rd_elig) begin
          w_state_nxt     = S_RD_REQ;
          w_cmd_valid_nxt = 1'b1;
          w_cmd_wr_nxt    = 1'b0;
          w_cmd_addr_nxt  = {c_pad, r_rd_bank, r_rd_off};
        end
      end
      S_WR_REQ: begin
        if (cmd_ready) begin
          w_state_nxt     = S_WR_BUSY;
          w_cmd_valid_nxt = 1'b0;
          w_last_wr_nxt   = 1'b1;
        end
      end
      S_WR_BUSY: begin
        if (burst_done) begin
          w_state_nxt  = S_IDLE;
          w_wr_off_nxt = r_wr_off + c_burst;
        end
      end
      S_RD_REQ: begin
        if (cmd_ready) begin
          w_state_nxt     = S_RD_BUSY;
          w_cmd_valid_nxt = 1'b0;
          w_last_wr_nxt   = 1'b0;
        end
      end
      S_RD_BUSY: begin
        if (burst_done) begin
          w_state_nxt = S_IDLE;
          // The display repeats the frame when no new vsync has arrived.
          if (r_rd_off + c_burst == c_frame) w_rd_off_nxt = '0;
          else                               w_rd_off_nxt = r_rd_off + c_burst;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_cmd_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and bookkeeping registers; reset abandons any burst in flight.
  always_ff @(posedge clk100m or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wr_off      <= '0;
      r_rd_off      <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_last_full   <= 1'b0;
      r_wr_pend     <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_last_wr     <= 1'b0;
      r_frame_ready <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd_wr      <= 1'b0;
      r_cmd_addr    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_off      <= w_wr_off_nxt;
      r_rd_off      <= w_rd_off_nxt;
      r_wr_bank     <= w_wr_bank_nxt;
      r_rd_bank     <= w_rd_bank_nxt;
      r_last_full   <= w_last_full_nxt;
      r_wr_pend     <= w_wr_pend_nxt;
      r_rd_pend     <= w_rd_pend_nxt;
      r_last_wr     <= w_last_wr_nxt;
      r_frame_ready <= w_frame_ready_nxt;
      r_cmd_valid   <= w_cmd_valid_nxt;
      r_cmd_wr      <= w_cmd_wr_nxt;
      r_cmd_addr    <= w_cmd_addr_nxt;
    end
  end

  assign cmd_valid   = r_cmd_valid;
  assign cmd_wr      = r_cmd_wr;
  assign cmd_addr    = r_cmd_addr;
  assign busy        = (r_state != S_IDLE);
  assign frame_ready = r_frame_ready;

endmodule
`default_nettype wire
